// File: rtl/branch_resolve_sequencer_pkg.sv
// Shared types and constants for the branch resolve sequencer and its decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package branch_resolve_sequencer_pkg;

  typedef enum logic [1:0] {
    BR_IDLE     = 2'd0,
    BR_WAIT     = 2'd1,
    BR_REDIRECT = 2'd2,
    BR_RELEASE  = 2'd3
  } br_state_e;

  // Status codes seen by the pipeline control decoder; 2'b10 is never driven.
  localparam logic [1:0] BR_STATUS_PENDING  = 2'b00;
  localparam logic [1:0] BR_STATUS_REDIRECT = 2'b01;
  localparam logic [1:0] BR_STATUS_RELEASE  = 2'b11;

  // Width of the WAIT timeout counter; TIMEOUT_CYCLES is limited to 1..255.
  localparam int TO_CNT_W = 8;

  // Status code presented for a given sequencer state.
  function automatic logic [1:0] br_status_of(input br_state_e s);
    logic [1:0] st;
    st = BR_STATUS_PENDING;
    case (s)
      BR_REDIRECT: st = BR_STATUS_REDIRECT;
      BR_RELEASE:  st = BR_STATUS_RELEASE;
      default:     st = BR_STATUS_PENDING;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/branch_resolve_sequencer_if.sv
// Bundle of decoder/EX-stage handshakes and sequencer outputs.
// Latency: n/a (wires only).
// Backpressure: stall_hold from the decoder freezes the sequencer.
interface branch_resolve_sequencer_if #(
  parameter int STAT_W = 32
);
  logic              jump_start;
  logic              stall_hold;
  logic              resolve_valid;
  logic              resolve_taken;
  logic              is_uncond;
  logic              stat_clear;
  logic [1:0]        branch_status;
  logic              take_branch;
  logic              busy;
  logic              timeout_err;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_taken;

  // Decoder / EX side: drives requests and results, observes the sequencer.
  modport master (
    output jump_start, stall_hold, resolve_valid, resolve_taken, is_uncond, stat_clear,
    input  branch_status, take_branch, busy, timeout_err, stat_branches, stat_taken
  );

  // Sequencer side.
  modport slave (
    input  jump_start, stall_hold, resolve_valid, resolve_taken, is_uncond, stat_clear,
    output branch_status, take_branch, busy, timeout_err, stat_branches, stat_taken
  );
endinterface

// File: rtl/branch_resolve_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Latency: count visible one edge after inc/clear.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear first, otherwise increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_resolve_sequencer.sv
// Sequences one control-flow instruction: wait for EX resolution, then redirect and release.
// Latency: jump_start -> WAIT next edge; WAIT exit -> REDIRECT (1 cycle) -> RELEASE (1 cycle).
// Backpressure: stall_hold freezes state, take_branch and the timeout count.
module branch_resolve_sequencer
  import branch_resolve_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int STAT_W         = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  branch_resolve_sequencer_if.slave   bus
);

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  br_state_e           state_q, state_d;
  logic                uncond_q, uncond_d;
  logic                take_q, take_d;
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic                timeout_err_q, timeout_err_d;
  logic                in_redirect_q, in_redirect_d;
  logic                stat_inc_br;
  logic                stat_inc_tk;

  // Next-state logic; stall_hold freezes everything except the statistics path.
  always_comb begin
    state_d       = state_q;
    uncond_d      = uncond_q;
    take_d        = take_q;
    to_cnt_d      = to_cnt_q;
    timeout_err_d = timeout_err_q;
    if (!bus.stall_hold) begin
      case (state_q)
        BR_IDLE: begin
          if (bus.jump_start) begin
            state_d  = BR_WAIT;
            uncond_d = bus.is_uncond;
            to_cnt_d = '0;
          end
        end
        BR_WAIT: begin
          if (uncond_q || bus.resolve_valid) begin
            state_d = BR_REDIRECT;
            take_d  = uncond_q | (bus.resolve_valid & bus.resolve_taken);
          end else if (to_cnt_q == TO_LAST) begin
            // No result arrived in time: fall through as not-taken and flag it.
            state_d       = BR_REDIRECT;
            take_d        = 1'b0;
            timeout_err_d = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + TO_CNT_W'(1);
          end
        end
        BR_REDIRECT: state_d = BR_RELEASE;
        BR_RELEASE:  state_d = BR_IDLE;
        default:     state_d = BR_IDLE;
      endcase
    end
  end

  // Count each instruction once, on its first REDIRECT cycle, even if REDIRECT is stretched by stalls.
  always_comb begin
    in_redirect_d = (state_q == BR_REDIRECT);
    stat_inc_br   = (state_q == BR_REDIRECT) && !in_redirect_q;
    stat_inc_tk   = stat_inc_br && take_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BR_IDLE;
      uncond_q      <= 1'b0;
      take_q        <= 1'b0;
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
      in_redirect_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      uncond_q      <= uncond_d;
      take_q        <= take_d;
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
      in_redirect_q <= in_redirect_d;
    end
  end

  sat_counter #(.W(STAT_W)) u_stat_branches (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.stat_clear),
    .inc   (stat_inc_br),
    .count (bus.stat_branches)
  );

  sat_counter #(.W(STAT_W)) u_stat_taken (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.stat_clear),
    .inc   (stat_inc_tk),
    .count (bus.stat_taken)
  );

  // Outputs come only from registered state.
  assign bus.branch_status = br_status_of(state_q);
  assign bus.take_branch   = take_q;
  assign bus.busy          = (state_q != BR_IDLE);
  assign bus.timeout_err   = timeout_err_q;

endmodule
